// File: rtl/wb_arbiter.sv
// Writeback merge stage feeding the register file write port: in-order pipeline
// writes take priority, long-latency results drain from a FIFO, and a pending scoreboard tracks outstanding long-latency destinations.
module wb_arbiter #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32,
  parameter int LL_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_we,
  input  logic [RFIDX_WIDTH-1:0] pipe_wa,
  input  logic [XLEN-1:0]        pipe_wd,
  input  logic                   ll_issue,
  input  logic [RFIDX_WIDTH-1:0] ll_issue_wa,
  input  logic                   ll_valid,
  output logic                   ll_ready,
  input  logic [RFIDX_WIDTH-1:0] ll_wa,
  input  logic [XLEN-1:0]        ll_wd,
  input  logic [RFIDX_WIDTH-1:0] qa1,
  input  logic [RFIDX_WIDTH-1:0] qa2,
  input  logic [RFIDX_WIDTH-1:0] qa3,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   busy3,
  output logic                   rf_we,
  output logic [RFIDX_WIDTH-1:0] rf_wa,
  output logic [XLEN-1:0]        rf_wd
);

  localparam int PTR_W = $clog2(LL_DEPTH);
  localparam int CNT_W = $clog2(LL_DEPTH + 1);

  // Handshake: a long-latency result transfers on a cycle where ll_valid && ll_ready;
  // the producer holds ll_wa/ll_wd stable while ll_valid is high and ll_ready is low.
  logic [RFIDX_WIDTH-1:0] fifo_wa [LL_DEPTH];
  logic [XLEN-1:0]        fifo_wd [LL_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [RFREG_NUM-1:0]   pending, pending_nxt;

  logic pipe_act, fifo_empty, push, pop;

  always_comb begin
    pipe_act   = pipe_we && (pipe_wa != '0);
    fifo_empty = (count == '0);
    ll_ready   = !reset && (count != CNT_W'(LL_DEPTH));
    push       = ll_valid && ll_ready && (ll_wa != '0);
    pop        = !reset && !pipe_act && !fifo_empty;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (!reset) begin
      if (pipe_act) begin
        rf_we = 1'b1;
        rf_wa = pipe_wa;
        rf_wd = pipe_wd;
      end else if (!fifo_empty) begin
        rf_we = 1'b1;
        rf_wa = fifo_wa[rd_ptr];
        rf_wd = fifo_wd[rd_ptr];
      end
    end
  end

  // Clear before set so an issue to the register being retired keeps it pending.
  always_comb begin
    pending_nxt = pending;
    if (pop)
      pending_nxt[fifo_wa[rd_ptr]] = 1'b0;
    if (ll_issue && (ll_issue_wa != '0))
      pending_nxt[ll_issue_wa] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= ll_wa;
      fifo_wd[wr_ptr] <= ll_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    busy1 = (qa1 != '0) && pending[qa1];
    busy2 = (qa2 != '0) && pending[qa2];
    busy3 = (qa3 != '0) && pending[qa3];
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback merge stage directly upstream of the register file's single write port (we3/wa3/wd3).
- Merges in-order pipeline writebacks with out-of-order results from the long-latency unit (iterative mul/div). Long-latency results pass through a small FIFO.
- Keeps a pending-destination scoreboard that decode queries for RAW/WAW stalls.

Parameters:
XLEN, 32, data width (matches `XLEN)
RFIDX_WIDTH, 5, register index width (matches `RFIDX_WIDTH)
RFREG_NUM, 32, number of architectural registers
LL_DEPTH, 2, long-latency result FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
pipe_we  in  1  pipeline writeback valid (WB stage)
pipe_wa  in  RFIDX_WIDTH  pipeline destination register
pipe_wd  in  XLEN  pipeline writeback data
ll_issue  in  1  long-latency op issued this cycle
ll_issue_wa  in  RFIDX_WIDTH  destination register of the issued op
ll_valid  in  1  long-latency result valid
ll_ready  out  1  FIFO can accept a result
ll_wa  in  RFIDX_WIDTH  long-latency result destination register
ll_wd  in  XLEN  long-latency result data
qa1, qa2, qa3  in  RFIDX_WIDTH  decode query indices (rs1, rs2, rd)
busy1, busy2, busy3  out  1  queried register has a pending long-latency write
rf_we  out  1  to register file we3
rf_wa  out  RFIDX_WIDTH  to register file wa3
rf_wd  out  XLEN  to register file wd3

Behaviour:
- Single clock clk. Reset is synchronous and active-high on port reset.
- While reset is sampled high:
  - FIFO empties (rd/wr pointers and count = 0).
  - pending[RFREG_NUM-1:0] = 0.
  - Outputs rf_we = 0 and ll_ready = 0; busy1/2/3 = 0 from the next edge.
- Reset asserted mid-operation discards buffered results and all pending bits. No partial write is emitted.
- A pipeline write counts only if pipe_we && pipe_wa != 0 ("pipe_act"). Writes to x0 are dropped everywhere.
- Write-port arbitration (combinational, same cycle):
  - If pipe_act: rf_we=1, rf_wa=pipe_wa, rf_wd=pipe_wd. The pipeline always wins and is never stalled.
  - Else if FIFO is non-empty: rf_we=1, rf_wa/rf_wd = FIFO head, and the head is popped at posedge.
  - Else rf_we=0; rf_wa/rf_wd = 0.
- FIFO:
  - ll_ready = !reset && (count != LL_DEPTH).
  - Push on ll_valid && ll_ready && ll_wa != 0.
  - ll_valid && ll_ready with ll_wa == 0 is accepted and discarded.
  - There is no bypass, so an accepted result appears on rf_we no earlier than the next cycle.
  - Simultaneous push and pop: count unchanged, pointers wrap modulo LL_DEPTH.
  - When full, ll_ready is 0 even if a pop occurs that cycle (no same-cycle refill).
- Scoreboard:
  - ll_issue && ll_issue_wa != 0 sets pending[ll_issue_wa].
  - A FIFO pop clears pending[popped wa].
  - If set and clear hit the same index in the same cycle, set wins.
  - Updates are visible on busy* the cycle after the edge.
- busyN = (qaN != 0) && pending[qaN], combinational from registered state.
- Decode contract:
  - No issue while busy3 for the same rd.
  - No pipeline write to a pending rd.
  - Violations are undefined; the bench asserts they do not occur.
- Ordering: the FIFO preserves long-latency completion order. Pipeline writes can overtake buffered results; the scoreboard contract makes this safe.
- Starvation bound: a FIFO head waits only while pipe_act is 1 every cycle.

Test Plan:
- Reset held 2 cycles with ll_valid=1 -> ll_ready=0, rf_we=0, no push. After release, count=0 and ll_ready=1.
- Pipe write only: pipe_we=1, pipe_wa=5, pipe_wd=0xDEADBEEF -> same cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. pipe_wa=0 -> rf_we=0.
- Issue rd=7 at cycle 0 -> busy1=1 with qa1=7 from cycle 1. Result ll_wa=7, ll_wd=0x12 at cycle 4 with pipe idle -> rf_we=1, rf_wa=7, rf_wd=0x12 at cycle 5. busy1=0 from cycle 6.
- Contention: FIFO holds rd=3 while pipe_act for rd=4,5,6 on three consecutive cycles -> rf_wa = 4,5,6, then 3 on the first idle cycle; pending[3] stays set until that pop.
- Full: LL_DEPTH=2 results pushed while pipe is busy -> ll_ready=0. Third result is held off until after the first pop; its wd matches input, order is preserved, and the pointers wrap.
- Same-cycle set/clear: pop of wa=9 and ll_issue wa=9 in the same cycle -> pending[9] remains 1 and busy reads 1 the next cycle.
